// File: rtl/tx_core.sv
// UART transmitter: words enter through a valid/ready handshake into a small FIFO
// and leave LSB-first as start / data / stop frames at BAUD_RATE cycles per bit.
module tx_core #(
  parameter int          DATA_WIDTH = 8,
  parameter logic [31:0] BAUD_RATE  = 32'd1667,
  parameter int          FIFO_DEPTH = 4,
  parameter int          STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Tx_data,
  input  logic                  Tx_valid,
  output logic                  Tx_ready,
  output logic                  Tx,
  output logic                  Tx_busy,
  output logic                  Tx_done
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              CW        = $clog2(FIFO_DEPTH + 1);
  localparam int              BCW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [31:0]     BIT_LAST  = BAUD_RATE - 32'd1;
  localparam logic [31:0]     STOP_LAST = 32'(STOP_BITS) * BAUD_RATE - 32'd1;
  localparam logic [BCW-1:0]  DATA_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]   FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q, state_nx;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] shift_q, shift_nx;
  logic [31:0]           timer_q, timer_nx;
  logic [BCW-1:0]        bit_q, bit_nx;
  logic                  tx_q, tx_nx;
  logic                  done_q, done_nx;
  logic                  push, pop, fifo_empty;

  // Ready is held low through reset so nothing is accepted until release.
  assign Tx_ready   = rst && (count != FULL);
  assign push       = Tx_valid && Tx_ready;
  assign fifo_empty = (count == '0);
  assign Tx         = tx_q;
  assign Tx_done    = done_q;
  assign Tx_busy    = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    state_nx = state_q;
    timer_nx = timer_q + 32'd1;
    bit_nx   = bit_q;
    shift_nx = shift_q;
    tx_nx    = tx_q;
    done_nx  = 1'b0;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        timer_nx = '0;
        tx_nx    = 1'b1;
        if (!fifo_empty) begin
          pop      = 1'b1;
          shift_nx = mem[rd_ptr];
          tx_nx    = 1'b0;
          state_nx = START;
        end
      end
      START: begin
        if (timer_q == BIT_LAST) begin
          tx_nx    = shift_q[0];
          shift_nx = shift_q >> 1;
          bit_nx   = '0;
          timer_nx = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_nx = '0;
          if (bit_q == DATA_LAST) begin
            tx_nx    = 1'b1;
            state_nx = STOP;
          end else begin
            tx_nx    = shift_q[0];
            shift_nx = shift_q >> 1;
            bit_nx   = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        // A buffered word starts on the same edge the done pulse is raised.
        if (timer_q == STOP_LAST) begin
          done_nx  = 1'b1;
          timer_nx = '0;
          if (!fifo_empty) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            tx_nx    = 1'b0;
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      timer_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      timer_q <= timer_nx;
      bit_q   <= bit_nx;
      tx_q    <= tx_nx;
      done_q  <= done_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage and shift register carry data only; they need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= Tx_data;
    shift_q <= shift_nx;
  end

endmodule

// File: tb/tb_tx_core.sv
// Bench for tx_core: per-cycle comparison of the serial line and done pulses
// against an expected waveform built from frame arithmetic.
`timescale 1ns/1ps
module tb_tx_core;
  localparam int B    = 4;
  localparam int DW   = 8;
  localparam int LOGN = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       ready1, tx1, busy1, done1;
  logic       ready2, tx2, busy2, done2;

  tx_core #(.DATA_WIDTH(8), .BAUD_RATE(32'd4), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .Tx_data(data1), .Tx_valid(valid1), .Tx_ready(ready1),
    .Tx(tx1), .Tx_busy(busy1), .Tx_done(done1));

  tx_core #(.DATA_WIDTH(8), .BAUD_RATE(32'd4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .Tx_data(data2), .Tx_valid(valid2), .Tx_ready(ready2),
    .Tx(tx2), .Tx_busy(busy2), .Tx_done(done2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Entry n holds the outputs seen after rising edge n.
  logic tx_log [LOGN];
  logic done_log [LOGN];
  logic busy_log [LOGN];
  logic ready_log [LOGN];
  logic tx2_log [LOGN];
  logic done2_log [LOGN];
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_log[cyc]    <= tx1;
      done_log[cyc]  <= done1;
      busy_log[cyc]  <= busy1;
      ready_log[cyc] <= ready1;
      tx2_log[cyc]   <= tx2;
      done2_log[cyc] <= done2;
    end
  end

  int checks = 0;
  int fails  = 0;
  logic [7:0] exp_bytes [$];
  logic       exp_tx [$];
  logic       exp_done [$];

  // Expected line level and done flag for each cycle from the start edge on.
  task automatic build_model(input int s);
    int L, n, f, slot;
    logic b;
    L = (1 + DW + s) * B;
    n = exp_bytes.size();
    exp_tx.delete();
    exp_done.delete();
    for (int j = 0; j <= n * L; j++) begin
      f    = j / L;
      slot = (j % L) / B;
      if (f >= n)          b = 1'b1;
      else if (slot == 0)  b = 1'b0;
      else if (slot <= DW) b = exp_bytes[f][slot-1];
      else                 b = 1'b1;
      exp_tx.push_back(b);
      exp_done.push_back(j > 0 && (j % L) == 0);
    end
  endtask

  task automatic push_word(input logic [7:0] d, output int k);
    data1  = d;
    valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    k = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; valid1 = 1'b1; data1 = 8'hEE; valid2 = 1'b0; data2 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ready1 !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready1); end
    checks++; if (tx1 !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx1); end
    checks++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy1); end
    checks++; if (done1 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done1); end
    @(posedge clk); #1;
    valid1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (ready1 !== 1'b1) begin fails++; $display("FAIL release_ready got %b want 1", ready1); end
    @(posedge clk); #1;
    checks++; if (busy1 !== 1'b0) begin fails++; $display("FAIL release_busy got %b want 0", busy1); end
    checks++; if (tx1 !== 1'b1) begin fails++; $display("FAIL release_tx got %b want 1", tx1); end
  endtask

  task automatic test_single();
    int k, t0;
    push_word(8'hA5, k);
    t0 = k + 1;
    checks++; if (tx1 !== 1'b1) begin fails++; $display("FAIL single_pre_start got %b want 1", tx1); end
    exp_bytes.delete(); exp_bytes.push_back(8'hA5);
    build_model(1);
    wait_until(t0 + exp_tx.size());
    for (int j = 0; j < exp_tx.size(); j++) begin
      checks++;
      if (tx_log[t0+j] !== exp_tx[j]) begin fails++; $display("FAIL single_tx at %0d got %b want %b", j, tx_log[t0+j], exp_tx[j]); end
      checks++;
      if (done_log[t0+j] !== exp_done[j]) begin fails++; $display("FAIL single_done at %0d got %b want %b", j, done_log[t0+j], exp_done[j]); end
    end
    checks++; if (busy_log[t0+39] !== 1'b1) begin fails++; $display("FAIL single_busy_mid got %b want 1", busy_log[t0+39]); end
    checks++; if (busy_log[t0+40] !== 1'b0) begin fails++; $display("FAIL single_busy_end got %b want 0", busy_log[t0+40]); end
  endtask

  task automatic test_back_to_back();
    int k, t0, kk;
    logic [7:0] w [4];
    w[0] = 8'h55; w[1] = 8'h0F; w[2] = 8'hFF; w[3] = 8'h00;
    exp_bytes.delete();
    for (int i = 0; i < 4; i++) begin
      push_word(w[i], kk);
      if (i == 0) k = kk;
      exp_bytes.push_back(w[i]);
    end
    t0 = k + 1;
    build_model(1);
    wait_until(t0 + exp_tx.size());
    for (int j = 0; j < exp_tx.size(); j++) begin
      checks++;
      if (tx_log[t0+j] !== exp_tx[j]) begin fails++; $display("FAIL b2b_tx at %0d got %b want %b", j, tx_log[t0+j], exp_tx[j]); end
      checks++;
      if (done_log[t0+j] !== exp_done[j]) begin fails++; $display("FAIL b2b_done at %0d got %b want %b", j, done_log[t0+j], exp_done[j]); end
    end
  endtask

  task automatic test_full_fifo();
    logic [7:0] w [6];
    logic [7:0] base;
    int idx, k, first_stall, guard, t0;
    logic acc;
    idx = 0; k = -1; first_stall = -1; guard = 0;
    base = 8'($urandom);
    for (int i = 0; i < 6; i++) w[i] = base + 8'(i * 41);
    while (idx < 6 && guard < 400) begin
      data1 = w[idx]; valid1 = 1'b1;
      @(negedge clk); acc = ready1;
      @(posedge clk); #1; guard++;
      if (acc) begin
        if (idx == 0) k = cyc;
        idx++;
      end else if (first_stall < 0) begin
        first_stall = idx;
      end
    end
    valid1 = 1'b0;
    checks++; if (idx != 6) begin fails++; $display("FAIL full_accepted got %0d want 6", idx); end
    checks++; if (first_stall != 5) begin fails++; $display("FAIL full_before_stall got %0d want 5", first_stall); end
    if (k < 0) k = cyc;
    t0 = k + 1;
    exp_bytes.delete();
    for (int i = 0; i < 6; i++) exp_bytes.push_back(w[i]);
    build_model(1);
    wait_until(t0 + exp_tx.size());
    checks++; if (ready_log[k+3] !== 1'b1) begin fails++; $display("FAIL full_ready_3buf got %b want 1", ready_log[k+3]); end
    checks++; if (ready_log[k+4] !== 1'b0) begin fails++; $display("FAIL full_ready_4buf got %b want 0", ready_log[k+4]); end
    checks++; if (ready_log[k+40] !== 1'b0) begin fails++; $display("FAIL full_ready_prepop got %b want 0", ready_log[k+40]); end
    checks++; if (ready_log[k+41] !== 1'b1) begin fails++; $display("FAIL full_ready_postpop got %b want 1", ready_log[k+41]); end
    for (int j = 0; j < exp_tx.size(); j++) begin
      checks++;
      if (tx_log[t0+j] !== exp_tx[j]) begin fails++; $display("FAIL full_tx at %0d got %b want %b", j, tx_log[t0+j], exp_tx[j]); end
      checks++;
      if (done_log[t0+j] !== exp_done[j]) begin fails++; $display("FAIL full_done at %0d got %b want %b", j, done_log[t0+j], exp_done[j]); end
    end
  endtask

  task automatic test_two_stop();
    int k, t0;
    data2 = 8'h3C; valid2 = 1'b1;
    @(posedge clk); #1;
    valid2 = 1'b0; k = cyc; t0 = k + 1;
    exp_bytes.delete(); exp_bytes.push_back(8'h3C);
    build_model(2);
    checks++; if (exp_tx.size() != 45) begin fails++; $display("FAIL stop2_frame_len got %0d want 45", exp_tx.size()); end
    wait_until(t0 + exp_tx.size());
    for (int j = 0; j < exp_tx.size(); j++) begin
      checks++;
      if (tx2_log[t0+j] !== exp_tx[j]) begin fails++; $display("FAIL stop2_tx at %0d got %b want %b", j, tx2_log[t0+j], exp_tx[j]); end
      checks++;
      if (done2_log[t0+j] !== exp_done[j]) begin fails++; $display("FAIL stop2_done at %0d got %b want %b", j, done2_log[t0+j], exp_done[j]); end
    end
  endtask

  task automatic test_reset_mid();
    int k, t0, r;
    push_word(8'hC3, k);
    t0 = k + 1;
    wait_until(t0 + 4 * B + 1);
    rst = 1'b0;
    @(posedge clk); #1;
    r = cyc;
    @(negedge clk);
    checks++; if (tx_log[r-1] !== 1'b0) begin fails++; $display("FAIL rstmid_bit3 got %b want 0", tx_log[r-1]); end
    checks++; if (tx1 !== 1'b1) begin fails++; $display("FAIL rstmid_tx got %b want 1", tx1); end
    checks++; if (busy1 !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy1); end
    @(posedge clk); #1;
    rst = 1'b1;
    wait_until(r + 6);
    for (int j = r; j < r + 6; j++) begin
      checks++;
      if (done_log[j] !== 1'b0) begin fails++; $display("FAIL rstmid_no_done at %0d got %b want 0", j, done_log[j]); end
      checks++;
      if (busy_log[j] !== 1'b0) begin fails++; $display("FAIL rstmid_flushed at %0d got %b want 0", j, busy_log[j]); end
    end
    push_word(8'h81, k);
    t0 = k + 1;
    exp_bytes.delete(); exp_bytes.push_back(8'h81);
    build_model(1);
    wait_until(t0 + exp_tx.size());
    for (int j = 0; j < exp_tx.size(); j++) begin
      checks++;
      if (tx_log[t0+j] !== exp_tx[j]) begin fails++; $display("FAIL rstmid_after_tx at %0d got %b want %b", j, tx_log[t0+j], exp_tx[j]); end
      checks++;
      if (done_log[t0+j] !== exp_done[j]) begin fails++; $display("FAIL rstmid_after_done at %0d got %b want %b", j, done_log[t0+j], exp_done[j]); end
    end
  endtask

  task automatic test_data_immunity();
    int k, t0;
    push_word(8'h12, k);
    t0 = k + 1;
    repeat (2) begin @(posedge clk); #1; end
    data1 = 8'hFF;
    exp_bytes.delete(); exp_bytes.push_back(8'h12);
    build_model(1);
    wait_until(t0 + exp_tx.size());
    for (int j = 0; j < exp_tx.size(); j++) begin
      checks++;
      if (tx_log[t0+j] !== exp_tx[j]) begin fails++; $display("FAIL immune_tx at %0d got %b want %b", j, tx_log[t0+j], exp_tx[j]); end
    end
  endtask

  task automatic test_random();
    int n, k, kk, t0;
    logic [7:0] d;
    for (int round = 0; round < 3; round++) begin
      n = $urandom_range(1, 4);
      exp_bytes.delete();
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        push_word(d, kk);
        if (i == 0) k = kk;
        exp_bytes.push_back(d);
      end
      t0 = k + 1;
      build_model(1);
      wait_until(t0 + exp_tx.size() + $urandom_range(0, 5));
      for (int j = 0; j < exp_tx.size(); j++) begin
        checks++;
        if (tx_log[t0+j] !== exp_tx[j]) begin fails++; $display("FAIL rand_tx r%0d at %0d got %b want %b", round, j, tx_log[t0+j], exp_tx[j]); end
        checks++;
        if (done_log[t0+j] !== exp_done[j]) begin fails++; $display("FAIL rand_done r%0d at %0d got %b want %b", round, j, done_log[t0+j], exp_done[j]); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_two_stop();
    test_reset_mid();
    test_data_immunity();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
